sysid_check_master: RTL and testbench
=====================================

SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 Parameter EXPECTED_ID, default 0, expected 32-bit system ID at word address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1537628501, expected 32-bit timestamp at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, maximum consecutive waitrequest cycles per read.
REQ-004 clock  input  1  single clock; all logic rising-edge, one clock domain.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 start  input  1  one-cycle request to begin a check sequence.
REQ-007 avm_address  output  1  Avalon-MM word address to sysid slave (0=ID, 1=timestamp).
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_readdata  input  32  read data from slave.
REQ-010 avm_waitrequest  input  1  slave stall; read completes on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-011 busy  output  1  high while a sequence is in progress.
REQ-012 done  output  1  high from sequence completion until next accepted start.
REQ-013 pass  output  1  high when done=1 and both words matched.
REQ-014 error_code  output  2  0 ok, 1 ID mismatch, 2 timestamp mismatch, 3 timeout.
REQ-015 id_value  output  32  captured ID word.
REQ-016 timestamp_value  output  32  captured timestamp word.

Function
REQ-017 The block SHALL implement FSM states IDLE, RD_ID, RD_TS, COMPARE, FINISH; all outputs registered.
REQ-018 IDLE: start=1 SHALL transition to RD_ID next edge, clearing done, pass, error_code, and setting busy=1.
REQ-019 start SHALL be ignored in every state except IDLE and FINISH; start in FINISH behaves as in IDLE.
REQ-020 RD_ID: avm_read=1, avm_address=0, held stable until a cycle with avm_waitrequest=0; on that edge id_value captures avm_readdata, state goes RD_TS.
REQ-021 RD_TS: avm_read=1, avm_address=1, same handshake; on completion timestamp_value captures avm_readdata, state goes COMPARE.
REQ-022 avm_read SHALL deassert for exactly the transition cycle between RD_ID and RD_TS is NOT required: avm_read stays 1 continuously, address changes 0->1 on the completing edge.
REQ-023 COMPARE (one cycle, avm_read=0): error_code = 1 if id_value!=EXPECTED_ID, else 2 if timestamp_value!=EXPECTED_TIMESTAMP, else 0; ID mismatch takes priority.
REQ-024 FINISH: busy=0, done=1, pass=(error_code==0); outputs held until start or reset.
REQ-025 With zero wait states, start-to-done latency SHALL be 4 cycles (RD_ID, RD_TS, COMPARE, then done visible).
REQ-026 avm_waitrequest SHALL be ignored whenever avm_read=0.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, error_code=0, id_value=0, timestamp_value=0, timeout counter=0.
REQ-028 Reset mid-read SHALL abort the transaction; avm_read low from the first edge with reset=1; start during reset ignored.

Configuration
REQ-029 Macro SYSID_CHECK_TIMEOUT_EN defined: a 16-bit counter SHALL count consecutive cycles with avm_read=1 and avm_waitrequest=1, cleared on each read completion; reaching TIMEOUT_CYCLES SHALL deassert avm_read next edge and go FINISH with error_code=3, pass=0.
REQ-030 Macro undefined: no counter exists; reads wait indefinitely; error_code 3 never produced.

Verification
REQ-031 Zero-wait slave returning 0 then 1537628501, start pulse -> done=1 and pass=1 four cycles later, error_code=0, id_value=0, timestamp_value=1537628501.
REQ-032 Slave returns ID 0x00000005 -> done=1, pass=0, error_code=1, id_value=5; timestamp still read and captured.
REQ-033 ID correct, timestamp 0 -> error_code=2, pass=0.
REQ-034 waitrequest held 3 cycles on each read -> avm_address/avm_read stable during stall, done at 10 cycles after start, pass=1.
REQ-035 SYSID_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> avm_read drops after 8 stall cycles, done=1, error_code=3; without macro, busy stays 1 for 1000 cycles.
REQ-036 reset asserted during RD_TS stall, then second start -> all outputs zero after reset edge; second sequence completes with pass=1.

Source files
------------

// File: rtl/sysid_check_master.sv
// sysid_check_master: reads the sysid ID and timestamp words over Avalon-MM and checks them.
// Optional read timeout is compiled in when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_check_master #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1537628501,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  error_code,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      COMPARE,
      FINISH
   } state_t;

   state_t r_state;

   logic       w_rd_done;
   logic       w_timeout;
   logic [1:0] w_err;

   assign w_rd_done = avm_read & ~avm_waitrequest;

   assign w_err = (id_value != EXPECTED_ID)               ? 2'd1 :
                  (timestamp_value != EXPECTED_TIMESTAMP) ? 2'd2 :
                                                            2'd0;

`ifdef SYSID_CHECK_TIMEOUT_EN
   logic [15:0] r_to_cnt;

   // Counts consecutive stalled read cycles; any non-stalled cycle restarts it.
   always_ff @(posedge clock) begin
      if (reset || !avm_read || !avm_waitrequest)
         r_to_cnt <= 16'd0;
      else
         r_to_cnt <= r_to_cnt + 16'd1;
   end

   assign w_timeout = avm_read & avm_waitrequest &
                      (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   // Without the timeout a stalled read waits forever; a zero budget is illegal.
   assign w_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= IDLE;
         avm_read        <= 1'b0;
         avm_address     <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         error_code      <= 2'd0;
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
      end else begin
         unique case (r_state)
            IDLE, FINISH: begin
               if (start) begin
                  r_state     <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  error_code  <= 2'd0;
               end
            end
            RD_ID, RD_TS: begin
               if (w_timeout) begin
                  r_state     <= FINISH;
                  avm_read    <= 1'b0;
                  avm_address <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= 1'b0;
                  error_code  <= 2'd3;
               end else if (w_rd_done) begin
                  if (r_state == RD_ID) begin
                     id_value    <= avm_readdata;
                     avm_address <= 1'b1;
                     r_state     <= RD_TS;
                  end else begin
                     timestamp_value <= avm_readdata;
                     avm_read        <= 1'b0;
                     avm_address     <= 1'b0;
                     r_state         <= COMPARE;
                  end
               end
            end
            COMPARE: begin
               r_state    <= FINISH;
               error_code <= w_err;
               pass       <= (w_err == 2'd0);
               busy       <= 1'b0;
               done       <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: random sysid check sequences against a latency/result model.
// Exercises the timeout path when SYSID_CHECK_TIMEOUT_EN is defined.
module tb_sysid_check_master;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1537628501;
   localparam int unsigned TO     = 8;
`ifdef SYSID_CHECK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy;
   logic        done;
   logic        pass;
   logic [1:0]  error_code;
   logic [31:0] id_value;
   logic [31:0] timestamp_value;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] s_word [2];
   int unsigned s_wait [2];
   int unsigned s_stalls [2];
   bit          stable_ok;
   logic [31:0] m_id;
   logic [31:0] m_ts;

   always #5 clock = ~clock;

   sysid_check_master #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .error_code     (error_code),
      .id_value       (id_value),
      .timestamp_value(timestamp_value)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave: stalls the first s_wait[a] read cycles of word a; noise when idle.
   task automatic drive_slave();
      int a;
      a = (avm_address === 1'b1) ? 1 : 0;
      avm_readdata = s_word[a];
      if (avm_read === 1'b1)
         avm_waitrequest = (s_stalls[a] < s_wait[a]);
      else
         avm_waitrequest = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      logic p_rd, p_wr, p_a, p_rst;
      int   a;
      p_rd  = avm_read;
      p_wr  = avm_waitrequest;
      p_a   = avm_address;
      p_rst = reset;
      @(posedge clock);
      #1;
      if (p_rd === 1'b1 && p_wr === 1'b1 && !p_rst) begin
         a = (p_a === 1'b1) ? 1 : 0;
         s_stalls[a]++;
         if (done !== 1'b1 && (avm_read !== 1'b1 || avm_address !== p_a))
            stable_ok = 1'b0;
      end
      drive_slave();
   endtask

   task automatic setup_slave(input logic [31:0] id, input logic [31:0] ts,
                              input int unsigned w0, input int unsigned w1);
      s_word[0]   = id;
      s_word[1]   = ts;
      s_wait[0]   = w0;
      s_wait[1]   = w1;
      s_stalls[0] = 0;
      s_stalls[1] = 0;
      stable_ok   = 1'b1;
   endtask

   task automatic run_seq(input logic [31:0] id, input logic [31:0] ts,
                          input int unsigned w0, input int unsigned w1,
                          input bit extra_start);
      int unsigned exp_lat;
      logic [1:0]  exp_err;
      int          cyc;
      setup_slave(id, ts, w0, w1);
      if (TO_EN && w0 >= TO) begin
         exp_lat = 1 + TO;
         exp_err = 2'd3;
      end else if (TO_EN && w1 >= TO) begin
         exp_lat = 2 + w0 + TO;
         exp_err = 2'd3;
         m_id    = id;
      end else begin
         exp_lat = 4 + w0 + w1;
         exp_err = (id != EXP_ID) ? 2'd1 : (ts != EXP_TS) ? 2'd2 : 2'd0;
         m_id    = id;
         m_ts    = ts;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      check("busy_after_start", busy, 1'b1);
      while (done !== 1'b1 && cyc < 3000) begin
         start = extra_start && (cyc == 2);
         tick();
         start = 1'b0;
         cyc++;
      end
      check("latency", cyc, exp_lat);
      check("done", done, 1'b1);
      check("busy_end", busy, 1'b0);
      check("read_end", avm_read, 1'b0);
      check("error_code", error_code, exp_err);
      check("pass", pass, exp_err == 2'd0);
      check("id_value", id_value, m_id);
      check("ts_value", timestamp_value, m_ts);
      check("stall_stable", stable_ok, 1'b1);
      tick();
      tick();
      check("done_held", done, 1'b1);
      check("err_held", error_code, exp_err);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_read"}, avm_read, 1'b0);
      check({tag, "_addr"}, avm_address, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_pass"}, pass, 1'b0);
      check({tag, "_err"}, error_code, 2'd0);
      check({tag, "_id"}, id_value, 32'd0);
      check({tag, "_ts"}, timestamp_value, 32'd0);
   endtask

   initial begin
      logic [31:0] rid, rts;
      int unsigned rw0, rw1, wmax;
      int          cyc;
      bit          busy_ok;
      reset = 1'b1;
      start = 1'b1;
      m_id  = 32'd0;
      m_ts  = 32'd0;
      setup_slave(EXP_ID, EXP_TS, 0, 0);
      drive_slave();
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      start = 1'b0;
      tick();
      check("idle_no_start", busy, 1'b0);

      run_seq(EXP_ID, EXP_TS, 0, 0, 1'b0);
      run_seq(32'd5, EXP_TS, 0, 0, 1'b0);
      run_seq(EXP_ID, 32'd0, 0, 0, 1'b0);
      run_seq(EXP_ID, EXP_TS, 3, 3, 1'b1);

      if (TO_EN) begin
         run_seq(EXP_ID, EXP_TS, 32'hFFFF_FFFF, 0, 1'b0);
         run_seq(EXP_ID, EXP_TS, 2, 32'hFFFF_FFFF, 1'b0);
         run_seq(EXP_ID, EXP_TS, TO - 1, TO - 1, 1'b0);
      end else begin
         setup_slave(EXP_ID, EXP_TS, 32'hFFFF_FFFF, 0);
         start = 1'b1;
         tick();
         start = 1'b0;
         busy_ok = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            tick();
            if (busy !== 1'b1 || avm_read !== 1'b1 || done !== 1'b0)
               busy_ok = 1'b0;
         end
         check("stuck_busy", busy_ok, 1'b1);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         m_id = 32'd0;
         m_ts = 32'd0;
         check_all_zero("stuck_reset");
      end

      // Abort during a stalled timestamp read, with start held through reset.
      setup_slave(EXP_ID, EXP_TS, 0, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (avm_address !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("reached_rd_ts", avm_address, 1'b1);
      tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      check_all_zero("abort");
      tick();
      check_all_zero("abort_hold");
      reset = 1'b0;
      start = 1'b0;
      m_id = 32'd0;
      m_ts = 32'd0;
      tick();
      run_seq(EXP_ID, EXP_TS, 0, 0, 1'b0);

      wmax = TO_EN ? 12 : 6;
      for (int n = 0; n < 40; n++) begin
         rid = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
         rts = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
         rw0 = $urandom_range(0, wmax);
         rw1 = $urandom_range(0, wmax);
         run_seq(rid, rts, rw0, rw1, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
